// File: rtl/pcpi_div_gen_if.sv
// PCPI coprocessor bus between the core (master) and the divider (slave).
// Handshake: the core holds pcpi_valid with a stable instruction until pcpi_ready pulses or it withdraws; the
// slave raises pcpi_wait once it claims the instruction and pulses pcpi_ready/pcpi_wr for one cycle with the result.
interface pcpi_div_gen_if;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );
endinterface

// File: rtl/pcpi_div_gen.sv
// RV32M DIV/DIVU/REM/REMU coprocessor: restoring divider retiring STEPS quotient bits per clock.
// Define PCPI_DIV_EARLY_OUT_EN to finish trivial divisions (zero divisor, overflow, |rs1|<|rs2|) in one cycle.
module pcpi_div_gen #(
    parameter int STEPS = 1
) (
    input  logic           clk,
    input  logic           reset,
    pcpi_div_gen_if.slave  pcpi,
    output logic [1:0]     dbg_state
);
    localparam int         N    = 32 / STEPS;
    localparam logic [5:0] LAST = 6'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic        ready_q, wr_q, wait_q;
    logic [31:0] rd_q;
    logic        ready_d, wr_d, wait_d;
    logic [31:0] rd_d;

    logic [31:0] q, r, d;
    logic [5:0]  cnt;
    logic        q_neg, r_neg, is_rem_q;

    logic        insn_match, accept, is_signed, is_rem;
    logic [31:0] mag_a, mag_b;
    logic        early_out;
    logic [31:0] load_q, load_r;
    logic [31:0] q_st, r_st;
    logic [32:0] r_sh;
    logic [31:0] result;

    // Decode and operand magnitudes
    assign insn_match = (pcpi.pcpi_insn[6:0] == 7'b0110011) &&
                        (pcpi.pcpi_insn[31:25] == 7'b0000001) &&
                        pcpi.pcpi_insn[14];
    assign is_signed  = ~pcpi.pcpi_insn[12];
    assign is_rem     = pcpi.pcpi_insn[13];
    assign accept     = (state == IDLE) && pcpi.pcpi_valid && insn_match && !ready_q;
    assign mag_a      = (is_signed && pcpi.pcpi_rs1[31]) ? -pcpi.pcpi_rs1 : pcpi.pcpi_rs1;
    assign mag_b      = (is_signed && pcpi.pcpi_rs2[31]) ? -pcpi.pcpi_rs2 : pcpi.pcpi_rs2;

`ifdef PCPI_DIV_EARLY_OUT_EN
    logic div_zero, ovf;
    assign div_zero  = (pcpi.pcpi_rs2 == 32'd0);
    assign ovf       = is_signed && (pcpi.pcpi_rs1 == 32'h8000_0000) && (pcpi.pcpi_rs2 == 32'hFFFF_FFFF);
    assign early_out = div_zero || ovf || (mag_a < mag_b);

    // Early-out loads the final magnitudes directly so DONE reuses the normal result path
    always_comb begin
        load_q = mag_a;
        load_r = 32'd0;
        if (div_zero) begin
            load_q = 32'hFFFF_FFFF;
            load_r = mag_a;
        end else if (ovf) begin
            load_q = 32'h8000_0000;
            load_r = 32'd0;
        end else if (mag_a < mag_b) begin
            load_q = 32'd0;
            load_r = mag_a;
        end
    end
`else
    assign early_out = 1'b0;
    assign load_q    = mag_a;
    assign load_r    = 32'd0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; a withdrawn pcpi_valid aborts a running division
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = early_out ? DONE : RUN;
            RUN: begin
                if (!pcpi.pcpi_valid)  state_nx = IDLE;
                else if (cnt == LAST)  state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Restoring division: STEPS shift/subtract steps per RUN cycle
    always_comb begin
        q_st = q;
        r_st = r;
        r_sh = 33'd0;
        for (int i = 0; i < STEPS; i++) begin
            r_sh = {r_st, q_st[31]};
            if (r_sh >= {1'b0, d}) begin
                r_sh = r_sh - {1'b0, d};
                q_st = {q_st[30:0], 1'b1};
            end else begin
                q_st = {q_st[30:0], 1'b0};
            end
            r_st = r_sh[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= 32'd0;
            r        <= 32'd0;
            d        <= 32'd0;
            cnt      <= 6'd0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            is_rem_q <= 1'b0;
        end else if (accept) begin
            q        <= load_q;
            r        <= load_r;
            d        <= mag_b;
            cnt      <= 6'd0;
            // A zero divisor must yield all-ones for DIV regardless of the dividend sign
            q_neg    <= is_signed && (pcpi.pcpi_rs1[31] ^ pcpi.pcpi_rs2[31]) && (pcpi.pcpi_rs2 != 32'd0);
            r_neg    <= is_signed && pcpi.pcpi_rs1[31];
            is_rem_q <= is_rem;
        end else if (state == RUN) begin
            q   <= q_st;
            r   <= r_st;
            cnt <= cnt + 6'd1;
        end
    end

    assign result = is_rem_q ? (r_neg ? -r : r) : (q_neg ? -q : q);

    // Output logic: next values of the registered bus outputs
    always_comb begin
        wait_d  = (state_nx == RUN) || (state_nx == DONE);
        ready_d = (state == DONE);
        wr_d    = (state == DONE);
        rd_d    = (state == DONE) ? result : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q  <= 1'b0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 32'd0;
        end else begin
            wait_q  <= wait_d;
            ready_q <= ready_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    assign pcpi.pcpi_wait  = wait_q;
    assign pcpi.pcpi_ready = ready_q;
    assign pcpi.pcpi_wr    = wr_q;
    assign pcpi.pcpi_rd    = rd_q;
    assign dbg_state       = state;
endmodule

// File: tb/tb_pcpi_div_gen.sv
// Bench for pcpi_div_gen: directed vector table and random operations against an arithmetic reference,
// run on a STEPS=1 and a STEPS=4 instance, plus abort, reset, non-matching and re-accept sequences.
module tb_pcpi_div_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid1, valid4;
    logic [31:0] insn, rs1, rs2;
    logic [1:0]  dbg1, dbg4;
    int          errors = 0;
    int          checks = 0;

    pcpi_div_gen_if b1();
    pcpi_div_gen_if b4();

    assign b1.pcpi_valid = valid1;
    assign b1.pcpi_insn  = insn;
    assign b1.pcpi_rs1   = rs1;
    assign b1.pcpi_rs2   = rs2;
    assign b4.pcpi_valid = valid4;
    assign b4.pcpi_insn  = insn;
    assign b4.pcpi_rs1   = rs1;
    assign b4.pcpi_rs2   = rs2;

    pcpi_div_gen #(.STEPS(1)) dut1 (.clk(clk), .reset(reset), .pcpi(b1.slave), .dbg_state(dbg1));
    pcpi_div_gen #(.STEPS(4)) dut4 (.clk(clk), .reset(reset), .pcpi(b4.slave), .dbg_state(dbg4));

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion before 1ms");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    function automatic logic [31:0] mk_insn(input logic [6:0] funct7, input logic [2:0] f3);
        return {funct7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Reference model: RISC-V M-extension semantics from plain arithmetic
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic sgn, rem;
        sgn = ~f3[0];
        rem = f3[1];
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
        if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return rem ? (a % b) : (a / b);
    endfunction

    function automatic int model_lat(input int sel, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = (sel == 1) ? 33 : 9;
`ifdef PCPI_DIV_EARLY_OUT_EN
        begin
            longint sa, sb;
            logic sgn;
            sgn = ~f3[0];
            sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
            sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
            if (sa < 0) sa = -sa;
            if (sb < 0) sb = -sb;
            if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || sa < sb) n = 1;
        end
`else
        if (f3 == 3'b000 && a == b) n = n + 0;
`endif
        return n;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 1) ? b1.pcpi_ready : b4.pcpi_ready;
    endfunction
    function automatic logic get_wait(input int sel);
        return (sel == 1) ? b1.pcpi_wait : b4.pcpi_wait;
    endfunction
    function automatic logic get_wr(input int sel);
        return (sel == 1) ? b1.pcpi_wr : b4.pcpi_wr;
    endfunction
    function automatic logic [31:0] get_rd(input int sel);
        return (sel == 1) ? b1.pcpi_rd : b4.pcpi_rd;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel == 1) valid1 = v;
        else          valid4 = v;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Driver: call at a negedge; returns at a negedge with valid dropped
    task automatic do_op(input int sel, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        int          lat, got_k;
        logic [31:0] got_rd;
        logic        got_wr;
        lat    = model_lat(sel, f3, a, b);
        got_k  = -1;
        got_rd = 32'd0;
        got_wr = 1'b0;
        insn   = mk_insn(7'b0000001, f3);
        rs1    = a;
        rs2    = b;
        set_valid(sel, 1'b1);
        @(posedge clk); #1;
        chk({name, " wait_after_accept"}, 32'(get_wait(sel)), 32'd1);
        @(negedge clk);
        rs1 = $urandom;
        rs2 = $urandom;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (get_ready(sel)) begin
                got_k  = k;
                got_rd = get_rd(sel);
                got_wr = get_wr(sel);
                break;
            end
        end
        chk({name, " latency"}, 32'(got_k), 32'(lat));
        chk({name, " rd"}, got_rd, exp);
        chk({name, " wr"}, 32'(got_wr), 32'd1);
        // valid still high: the cycle after ready must not restart or repeat
        @(posedge clk); #1;
        chk({name, " no_restart_ready"}, 32'(get_ready(sel)), 32'd0);
        chk({name, " no_restart_wait"}, 32'(get_wait(sel)), 32'd0);
        chk({name, " rd_zero_after"}, get_rd(sel), 32'd0);
        @(negedge clk);
        set_valid(sel, 1'b0);
    endtask

    vec_t vecs[11];

    initial begin
        int          pulses;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          sel;

        vecs[0]  = '{F_DIVU, 32'd100, 32'd7, 32'd14};
        vecs[1]  = '{F_REMU, 32'd100, 32'd7, 32'd2};
        vecs[2]  = '{F_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2};
        vecs[3]  = '{F_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE};
        vecs[4]  = '{F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF};
        vecs[5]  = '{F_REMU, 32'd5, 32'd0, 32'd5};
        vecs[6]  = '{F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[7]  = '{F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        vecs[8]  = '{F_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[9]  = '{F_REM, 32'd7, 32'hFFFF_FFFE, 32'd1};
        vecs[10] = '{F_DIVU, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999};

        reset  = 1'b1;
        valid1 = 1'b0;
        valid4 = 1'b0;
        insn   = 32'd0;
        rs1    = 32'd0;
        rs2    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", {31'd0, b1.pcpi_ready} | {31'd0, b4.pcpi_ready}, 32'd0);
        chk("reset wait", {31'd0, b1.pcpi_wait} | {31'd0, b4.pcpi_wait}, 32'd0);
        chk("reset rd", b1.pcpi_rd | b4.pcpi_rd, 32'd0);
        chk("reset state", {28'd0, dbg1, dbg4}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table on both step widths
        for (int i = 0; i < 11; i++) begin
            do_op(1, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d_s1", i));
            do_op(4, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d_s4", i));
        end

        // Abort: valid withdrawn in RUN cycle 10
        insn = mk_insn(7'b0000001, F_DIVU);
        rs1 = 32'd1000;
        rs2 = 32'd3;
        valid1 = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        valid1 = 1'b0;
        @(posedge clk); #1;
        chk("abort wait_low", 32'(b1.pcpi_wait), 32'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (b1.pcpi_ready || b1.pcpi_wr) pulses++;
        end
        chk("abort no_pulse", 32'(pulses), 32'd0);
        @(negedge clk);
        do_op(1, F_DIVU, 32'd9, 32'd3, 32'd3, "after_abort");

        // Reset mid-RUN
        insn = mk_insn(7'b0000001, F_DIV);
        rs1 = 32'd12345;
        rs2 = 32'd11;
        valid1 = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        valid1 = 1'b0;
        @(posedge clk); #1;
        chk("midrun_reset outputs", {b1.pcpi_rd[31:3], b1.pcpi_ready, b1.pcpi_wr, b1.pcpi_wait} | b1.pcpi_rd, 32'd0);
        chk("midrun_reset state", 32'(dbg1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (b1.pcpi_ready) pulses++;
        end
        chk("midrun_reset no_pulse", 32'(pulses), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_op(1, F_DIVU, 32'd9, 32'd3, 32'd3, "first_edge_after_reset");

        // Non-matching instructions never claim the bus
        pulses = 0;
        insn = mk_insn(7'b0000001, 3'b000);
        rs1 = 32'd6;
        rs2 = 32'd7;
        valid1 = 1'b1;
        valid4 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (b1.pcpi_wait || b4.pcpi_wait || b1.pcpi_ready || b4.pcpi_ready) pulses++;
            if (k == 3) insn = mk_insn(7'b0000000, F_DIV);
        end
        chk("nonmatch no_wait", 32'(pulses), 32'd0);
        @(negedge clk);
        valid1 = 1'b0;
        valid4 = 1'b0;

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            sel = ($urandom_range(0, 1) == 0) ? 1 : 4;
            f3  = 3'(4 + $urandom_range(0, 3));
            a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = a + 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            do_op(sel, f3, a, b, model(f3, a, b), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
